seq_detector_param: RTL and testbench

//  Parametrised serial bit-pattern detector; next generation of the fixed 4-bit Mealy detector.

---
 rtl/seq_detector_param_pkg.sv | 21 ++
 rtl/seq_match_cmp.sv | 30 +++
 rtl/seq_detector_param.sv | 107 ++++++++++
 tb/tb_seq_detector_param.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/seq_detector_param_pkg.sv
// seq_detector_param_pkg: shared constants and types for the parametrised sequence detector.
//   MODE_MEALY / MODE_MOORE : output-mode encodings
//   OVL_OFF / OVL_ON        : overlap-mode encodings
//   DEF_PAT_4 / DEF_LEN_4   : default 4-bit pattern (1001) and length
//   mode_cfg_t              : packed overlap/output-mode configuration register
package seq_detector_param_pkg;

    localparam logic MODE_MEALY = 1'b0;
    localparam logic MODE_MOORE = 1'b1;
    localparam logic OVL_OFF    = 1'b0;
    localparam logic OVL_ON     = 1'b1;

    localparam logic [3:0] DEF_PAT_4 = 4'b1001;
    localparam int         DEF_LEN_4 = 4;

    typedef struct packed {
        logic ovl;
        logic moore;
    } mode_cfg_t;

endpackage

// File: rtl/seq_match_cmp.sv
// seq_match_cmp: masked compare of the candidate window against the pattern, qualified by fill level.
//   cand_i    in  PAT_W  history window including the current bit (bit 0 = newest)
//   pat_i     in  PAT_W  pattern ([len-1] first bit, [0] last bit)
//   len_i     in  LEN_W  active pattern length (0 disables matching)
//   fill_i    in  LEN_W  valid history bits held before the current bit
//   hit_raw_o out 1      pattern matches over len bits and enough history is valid
module seq_match_cmp #(
    parameter  int PAT_W = 4,
    localparam int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic [PAT_W-1:0] cand_i,
    input  logic [PAT_W-1:0] pat_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic [LEN_W-1:0] fill_i,
    output logic             hit_raw_o
);

    logic [PAT_W-1:0] mask;

    always_comb begin
        mask = '0;
        for (int i = 0; i < PAT_W; i++) mask[i] = i < int'(len_i);
    end

    // The current bit supplies one of the len bits, so len-1 history bits suffice.
    assign hit_raw_o = (len_i != '0) &&
                       (fill_i >= len_i - LEN_W'(1)) &&
                       (((cand_i ^ pat_i) & mask) == '0);

endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: runtime-configurable serial pattern detector with overlap and Mealy/Moore modes.
//   clk       in  1      rising-edge clock
//   rst_n     in  1      asynchronous reset, active low
//   en        in  1      in_bit valid this cycle
//   in_bit    in  1      serial data bit
//   cfg_load  in  1      capture cfg_* (drops a same-cycle data bit)
//   cfg_pat   in  PAT_W  new pattern
//   cfg_len   in  LEN_W  new length (clamped to PAT_W, 0 disables)
//   cfg_ovl   in  1      new overlap mode
//   cfg_moore in  1      new output mode
//   cnt_clr   in  1      clear match counter (wins over a same-cycle hit)
//   z         out 1      match indication
//   match_cnt out CNT_W  saturating match count
//   fill_out  out LEN_W  valid history bits held
module seq_detector_param
    import seq_detector_param_pkg::*;
#(
    parameter  int               PAT_W     = 4,
    parameter  int               CNT_W     = 8,
    parameter  logic [PAT_W-1:0] DEF_PAT   = DEF_PAT_4,
    parameter  int               DEF_LEN   = DEF_LEN_4,
    parameter  logic             DEF_OVL   = OVL_ON,
    parameter  logic             DEF_MOORE = MODE_MEALY,
    localparam int               LEN_W     = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_bit,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pat,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_ovl,
    input  logic             cfg_moore,
    input  logic             cnt_clr,
    output logic             z,
    output logic [CNT_W-1:0] match_cnt,
    output logic [LEN_W-1:0] fill_out
);

    // The oldest history bit is shifted out before it can ever be compared, so it is not stored.
    logic [PAT_W-2:0] hist_q, hist_d;
    logic [LEN_W-1:0] fill_q, fill_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    mode_cfg_t        mode_q, mode_d;
    logic             z_q, z_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [PAT_W-1:0] cand;
    logic             hit_raw;
    logic             hit;

    assign cand = {hist_q, in_bit};

    seq_match_cmp #(.PAT_W(PAT_W)) u_cmp (
        .cand_i   (cand),
        .pat_i    (pat_q),
        .len_i    (len_q),
        .fill_i   (fill_q),
        .hit_raw_o(hit_raw)
    );

    // A configuration load discards the bit presented in the same cycle.
    assign hit = en & ~cfg_load & hit_raw;

    always_comb begin
        hist_d = cfg_load ? '0 : en ? cand[PAT_W-2:0] : hist_q;
        fill_d = cfg_load                          ? '0 :
                 !en                               ? fill_q :
                 (hit && mode_q.ovl == OVL_OFF)    ? '0 :
                 (fill_q == LEN_W'(PAT_W))         ? fill_q : fill_q + LEN_W'(1);
        pat_d  = cfg_load ? cfg_pat : pat_q;
        len_d  = !cfg_load                  ? len_q :
                 (cfg_len > LEN_W'(PAT_W))  ? LEN_W'(PAT_W) : cfg_len;
        mode_d = cfg_load ? '{ovl: cfg_ovl, moore: cfg_moore} : mode_q;
        z_d    = hit;
        cnt_d  = cnt_clr                ? '0 :
                 (hit && cnt_q != '1)   ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
            fill_q <= '0;
            pat_q  <= DEF_PAT;
            len_q  <= LEN_W'(DEF_LEN);
            mode_q <= '{ovl: DEF_OVL, moore: DEF_MOORE};
            z_q    <= 1'b0;
            cnt_q  <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            pat_q  <= pat_d;
            len_q  <= len_d;
            mode_q <= mode_d;
            z_q    <= z_d;
            cnt_q  <= cnt_d;
        end
    end

    // Gating with rst_n keeps a combinational Mealy hit from appearing while reset is held.
    assign z         = rst_n & ((mode_q.moore == MODE_MOORE) ? z_q : hit);
    assign match_cnt = cnt_q;
    assign fill_out  = fill_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: directed self-checking bench for seq_detector_param (4-bit and 8-bit instances).
module tb_seq_detector_param;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    logic       a_en = 0, a_bit = 0, a_load = 0, a_ovl = 0, a_moore = 0, a_clr = 0;
    logic [3:0] a_pat = 0;
    logic [2:0] a_len = 0;
    logic       a_z;
    logic [7:0] a_cnt;
    logic [2:0] a_fill;

    logic       b_en = 0, b_bit = 0, b_load = 0, b_ovl = 0, b_moore = 0, b_clr = 0;
    logic [7:0] b_pat = 0;
    logic [3:0] b_len = 0;
    logic       b_z;
    logic [1:0] b_cnt;
    logic [3:0] b_fill;

    logic [7:0] a5 = 8'hA5;

    always #5 clk = ~clk;

    seq_detector_param u_a (
        .clk(clk), .rst_n(rst_n), .en(a_en), .in_bit(a_bit), .cfg_load(a_load),
        .cfg_pat(a_pat), .cfg_len(a_len), .cfg_ovl(a_ovl), .cfg_moore(a_moore),
        .cnt_clr(a_clr), .z(a_z), .match_cnt(a_cnt), .fill_out(a_fill)
    );

    seq_detector_param #(.PAT_W(8), .CNT_W(2), .DEF_PAT(8'hA5), .DEF_LEN(8)) u_b (
        .clk(clk), .rst_n(rst_n), .en(b_en), .in_bit(b_bit), .cfg_load(b_load),
        .cfg_pat(b_pat), .cfg_len(b_len), .cfg_ovl(b_ovl), .cfg_moore(b_moore),
        .cnt_clr(b_clr), .z(b_z), .match_cnt(b_cnt), .fill_out(b_fill)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic a_send(input logic b, input int exp_z, input string tag);
        a_bit = b;
        a_en = 1'b1;
        @(negedge clk);
        chk(tag, 32'(a_z), exp_z);
        @(posedge clk);
        #1;
        a_en = 1'b0;
    endtask

    task automatic b_send(input logic b, input int exp_z, input string tag);
        b_bit = b;
        b_en = 1'b1;
        @(negedge clk);
        chk(tag, 32'(b_z), exp_z);
        @(posedge clk);
        #1;
        b_en = 1'b0;
    endtask

    task automatic a_stream(input logic [15:0] bits, input logic [15:0] zs, input int n, input string tag);
        for (int i = n - 1; i >= 0; i--) a_send(bits[i], zs[i] ? 1 : 0, $sformatf("%s_b%0d", tag, n - i));
    endtask

    task automatic b_stream(input logic [15:0] bits, input logic [15:0] zs, input int n, input string tag);
        for (int i = n - 1; i >= 0; i--) b_send(bits[i], zs[i] ? 1 : 0, $sformatf("%s_b%0d", tag, n - i));
    endtask

    task automatic a_cfg(input logic [3:0] p, input logic [2:0] l, input logic o, input logic m, input logic c);
        a_pat = p; a_len = l; a_ovl = o; a_moore = m; a_clr = c; a_load = 1'b1;
        @(posedge clk);
        #1;
        a_load = 1'b0; a_clr = 1'b0;
    endtask

    initial begin
        #1;
        chk("rst_a_z", 32'(a_z), 0);
        chk("rst_a_cnt", 32'(a_cnt), 0);
        chk("rst_b_z", 32'(b_z), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_a_fill", 32'(a_fill), 0);
        chk("rst_b_fill", 32'(b_fill), 0);

        // Defaults, overlapping Mealy: hits on bits 4 and 7
        a_stream(16'b1001001, 16'b0001001, 7, "t1");
        chk("t1_cnt", 32'(a_cnt), 2);
        chk("t1_fill", 32'(a_fill), 4);

        // Broken prefix must not leave the detector armed
        a_cfg(4'b1001, 3'd4, 1'b1, 1'b0, 1'b1);
        chk("t2_fill_after_load", 32'(a_fill), 0);
        a_stream(16'b10001, 16'b00000, 5, "t2");
        chk("t2_cnt", 32'(a_cnt), 0);

        // Non-overlapping: bit 7 cannot reuse bit 4, next hit needs 4 fresh bits
        a_cfg(4'b1001, 3'd4, 1'b0, 1'b0, 1'b1);
        a_stream(16'b10010011001, 16'b00010000001, 11, "t3");
        chk("t3_cnt", 32'(a_cnt), 2);

        // Moore, pattern 110: z one cycle after the completing edge
        a_cfg(4'b0110, 3'd3, 1'b1, 1'b1, 1'b1);
        a_stream(16'b110, 16'b000, 3, "t4");
        @(negedge clk);
        chk("t4_moore_z", 32'(a_z), 1);
        chk("t4_fill", 32'(a_fill), 3);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t4_moore_z_drop", 32'(a_z), 0);
        chk("t4_cnt", 32'(a_cnt), 1);
        @(posedge clk);
        #1;

        // len=1: every matching bit hits
        a_cfg(4'b0001, 3'd1, 1'b0, 1'b0, 1'b0);
        a_stream(16'b101, 16'b101, 3, "t4b");
        chk("t4b_cnt", 32'(a_cnt), 3);

        // cfg_load beats a same-cycle matching bit
        a_pat = 4'b0001; a_len = 3'd1; a_ovl = 1'b0; a_moore = 1'b0;
        a_load = 1'b1; a_en = 1'b1; a_bit = 1'b1;
        @(negedge clk);
        chk("t4c_load_prio_z", 32'(a_z), 0);
        @(posedge clk);
        #1;
        a_load = 1'b0; a_en = 1'b0;
        chk("t4c_cnt", 32'(a_cnt), 3);

        // cfg_len above PAT_W clamps to PAT_W
        a_cfg(4'b1001, 3'd7, 1'b1, 1'b0, 1'b0);
        a_stream(16'b1001, 16'b0001, 4, "t4d");
        chk("t4d_cnt", 32'(a_cnt), 4);

        // 8-bit instance: A5 x5, counter saturates at 3
        for (int i = 0; i < 40; i++)
            b_send(a5[7 - (i % 8)], (i % 8 == 7) ? 1 : 0, $sformatf("t5_b%0d", i + 1));
        chk("t5_cnt_sat", 32'(b_cnt), 3);
        b_stream(16'b1010010, 16'b0, 7, "t5_pre");
        b_clr = 1'b1;
        b_send(1'b1, 1, "t5_clr_hit_z");
        b_clr = 1'b0;
        chk("t5_clr_cnt", 32'(b_cnt), 0);
        b_stream(16'b1010, 16'b0, 4, "t5_mid");
        b_pat = 8'hA5; b_len = 4'd8; b_ovl = 1'b1; b_moore = 1'b0; b_load = 1'b1;
        @(posedge clk);
        #1;
        b_load = 1'b0;
        chk("t5_load_fill", 32'(b_fill), 0);
        b_stream(16'h05A5, 16'h0001, 12, "t5_post");
        chk("t5_post_cnt", 32'(b_cnt), 1);

        // Mid-stream asynchronous reset
        a_cfg(4'b1001, 3'd4, 1'b1, 1'b0, 1'b0);
        a_stream(16'b100, 16'b000, 3, "t6");
        chk("t6_cnt_pre", 32'(a_cnt), 4);
        rst_n = 1'b0;
        a_bit = 1'b1;
        a_en = 1'b1;
        #1;
        chk("t6_rst_z", 32'(a_z), 0);
        chk("t6_rst_cnt", 32'(a_cnt), 0);
        chk("t6_rst_fill", 32'(a_fill), 0);
        chk("t6_rst_b_fill", 32'(b_fill), 0);
        a_en = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        a_send(1'b1, 0, "t6_post_z");
        chk("t6_post_fill", 32'(a_fill), 1);
        chk("t6_post_cnt", 32'(a_cnt), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
